serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes Diff = A - B - Bin over WIDTH clock cycles, LSB first, using one full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the team's combinational adder blocks. It trades latency for area.
- Operands are accepted through a start/busy/done handshake. It sits beside the adders in the arithmetic-blocks collection.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//   - state_e   : FSM state encoding (IDLE / SHIFT / DONE)
//   - cnt_width : bit-counter width helper, never narrower than one bit
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   Single-bit combinational full subtractor: d = a - b - bin.
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow in
//     d    : difference bit
//     bout : borrow out (1 when a < b + bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing Diff = A - B - Bin, LSB first, one bit per
//   clock through a single full-subtractor cell and a borrow flip-flop.
//   Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow
//   output ovf, registered alongside Diff.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; operands latched on accepted start
//   SHIFT  | one bit processed per cycle, WIDTH cycles in total
//   DONE   | result copied to output registers, done pulse issued
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     start : request, sampled only in IDLE
//     A, B  : minuend / subtrahend, captured on accepted start
//     Bin   : borrow in, captured on accepted start
//     busy  : high in SHIFT and DONE
//     done  : one-cycle pulse, result valid from this cycle
//     Diff  : registered difference, held until the next done
//     Bout  : registered borrow out (unsigned underflow)
//     ovf   : (macro only) signed two's-complement overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] r_sr_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // Outputs of the shared cell: next result bit and next borrow.
  logic bit_d;
  logic br_d;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_d)
  );

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Borrow entering the MSB step; XOR with the final borrow gives signed ovf.
  logic br_msb_q;
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_msb_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state_q == ST_SHIFT && cnt_q == LAST_BIT) begin
        br_msb_q <= br_q;
      end
      if (state_q == ST_DONE) begin
        ovf_q <= br_msb_q ^ br_q;
      end
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q  <= A;
            b_sr_q  <= B;
            br_q    <= Bin;
            r_sr_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          br_q   <= br_d;
          r_sr_q <= {bit_d, r_sr_q[WIDTH-1:1]};
          a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          diff_q  <= r_sr_q;
          bout_q  <= br_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int BUSY_CYCLES = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference timing model state
  int               m_cnt     = 0;
  logic             exp_done  = 1'b0;
  logic [WIDTH-1:0] exp_diff  = '0;
  logic             exp_bout  = 1'b0;
  logic             exp_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bin);
    exp_t e;
    int   ua, ub, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(WIDTH-1)) ? ua - 2**WIDTH : ua;
    sb = (ub >= 2**(WIDTH-1)) ? ub - 2**WIDTH : ub;
    sd = sa - sb - int'(bin);
    e.diff = WIDTH'(ua - ub - int'(bin));
    e.bout = (ua < ub + int'(bin));
    e.ovf  = (sd < -(2**(WIDTH-1))) || (sd > 2**(WIDTH-1) - 1);
    return e;
  endfunction

  // Model: advance on each rising edge, check on each falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cnt    = 0;
        exp_done = 1'b0;
      end else if (m_cnt == 0) begin
        exp_done = 1'b0;
        if (start) begin
          sb_q.push_back(calc(A, B, Bin));
          m_cnt = BUSY_CYCLES;
        end
      end else begin
        m_cnt--;
        exp_done = (m_cnt == 0);
      end

      @(negedge clk);
      if (!rst_n) begin
        m_cnt    = 0;
        exp_done = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        sb_q.delete();
      end
      check_val("busy", busy, m_cnt != 0);
      check_val("done", done, exp_done);
      if (done) begin
        check_val("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          exp_diff = e.diff;
          exp_bout = e.bout;
          exp_ovf  = e.ovf;
        end
      end
      check_val("diff", Diff, exp_diff);
      check_val("bout", Bout, exp_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check_val("ovf", ovf, exp_ovf);
`endif
    end
  end

  task automatic drive(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin);
    @(posedge clk);
    #2;
    start = s;
    A     = a;
    B     = b;
    Bin   = bin;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_cnt != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("idle_timeout", m_cnt == 0, 1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    drive(1'b1, a, b, bin);
    drive(1'b0, a, b, bin);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic operations and borrow/underflow cases
    run_op(4'b0011, 4'b0001, 1'b0);
    run_op(4'b0000, 4'b0001, 1'b0);
    run_op(4'b1010, 4'b0101, 1'b1);
    run_op(4'b0101, 4'b1010, 1'b0);
    run_op(4'b0011, 4'b0001, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b1);
    run_op(4'b1000, 4'b0001, 1'b0);

    // Start while busy is ignored; operands changing after accept are ignored
    drive(1'b1, 4'b0111, 4'b0010, 1'b0);
    drive(1'b0, 4'b1111, 4'b1111, 1'b1);
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    drive(1'b0, 4'b0000, 4'b0001, 1'b0);
    wait_idle();

    // Reset in the middle of SHIFT aborts without a done pulse
    drive(1'b1, 4'b0110, 4'b0001, 1'b0);
    drive(1'b0, 4'b0110, 4'b0001, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_op(4'b1000, 4'b0001, 1'b0);

    // Start held high: back-to-back accepts with random operands
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, WIDTH'($urandom_range(0, 2**WIDTH - 1)),
            WIDTH'($urandom_range(0, 2**WIDTH - 1)), 1'($urandom_range(0, 1)));
    end
    drive(1'b0, '0, '0, 1'b0);
    wait_idle();

    // Random isolated operations
    for (int i = 0; i < 8; i++) begin
      run_op(WIDTH'($urandom_range(0, 2**WIDTH - 1)), WIDTH'($urandom_range(0, 2**WIDTH - 1)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
